sdram_multibank_model: RTL and testbench
========================================

// Module: sdram_multibank_model
// PURPOSE
//  Parametrised SDRAM behavioural target for the bus-interface labs: decodes CS/RAS/CAS/WE commands,
//  keeps per-bank open-row state with tRCD/tRP/tRFC timing, stores data in a real array and returns
//  read data after a programmable CAS latency. Sits on the memory side of the controller under test.
//  Illegal or too-early commands are flagged, not executed.
// PARAMETERS
//  DW      8   data width
//  AW      12  address bus width; A[AW-1] = precharge-all flag
//  ROW_W   4   row bits, A[ROW_W-1:0] at ACTIVATE (ROW_W < AW)
//  COL_W   4   column bits, A[COL_W-1:0] at READ/WRITE (COL_W < AW)
//  BA_W    1   bank-address width; BANKS = 2**BA_W
//  CAS_LAT 2   READ-to-data latency in cycles (1..4)
//  T_RCD   2   ACTIVATE-to-READ/WRITE minimum, cycles (>=1)
//  T_RP    2   PRECHARGE-to-ACTIVATE minimum, cycles (>=1)
//  T_RFC   4   REFRESH busy time, cycles (>=1)
// PORTS
//  CLK       in   1        clock, all activity on posedge
//  RST_N     in   1        synchronous active-low reset
//  CS        in   1        chip select, active high; CS=0 -> NOP
//  RAS       in   1        row strobe, active high
//  CAS       in   1        column strobe, active high
//  WE        in   1        write enable, active high
//  BA        in   BA_W     bank address
//  A         in   AW       row/column address, A[AW-1] precharge-all
//  DQ_IN     in   DW       write data, sampled with WRITE
//  DQ_OUT    out  DW       read data
//  DQ_OE     out  1        DQ_OUT valid
//  BANK_OPEN out  2**BA_W  bit b = bank b ACTIVE (row open, tRCD met)
//  CMD_ERR   out  1        one-cycle pulse: last sampled command illegal, ignored
// BEHAVIOUR
//  Clock CLK, reset RST_N: one clock; reset is synchronous and active-low.
//  Reset (RST_N=0 at posedge): banks IDLE, all timers 0, read pipe flushed, DQ_OUT=0, DQ_OE=0,
//   BANK_OPEN=0, CMD_ERR=0; array contents untouched. Reset mid-read discards in-flight data.
//  Command {RAS,CAS,WE} when CS=1: 000 NOP, 100 ACT, 010 READ, 011 WRITE, 101 PRE, 110 REF; 001,111 illegal.
//  Per-bank FSM: IDLE -ACT-> OPENING (T_RCD) -> ACTIVE -PRE-> CLOSING (T_RP) -> IDLE.
//   ACT at edge n latches row; READ/WRITE legal from edge n+T_RCD. PRE at edge n: ACT legal from n+T_RP.
//   PRE on IDLE bank = legal no-op. PRE with A[AW-1]=1 closes all non-IDLE banks (each starts T_RP).
//  WRITE: mem[BA][row][col] <= DQ_IN at the command edge.
//  READ: array read at command edge; value on DQ_OUT with DQ_OE=1 for exactly one cycle, CAS_LAT
//   edges later. Back-to-back READs stream one word per cycle. Later WRITE to same address does not
//   alter in-flight data; READ in same cycle after WRITE edge sees new data (WRITE earlier cycle).
//  DQ_OUT holds last value when DQ_OE=0.
//  REF: legal only with all banks IDLE; chip BUSY T_RFC cycles, any non-NOP during BUSY is illegal.
//  CMD_ERR=1 the cycle after: illegal code; ACT to non-IDLE bank; READ/WRITE to non-ACTIVE bank or
//   before T_RCD; REF with a bank not IDLE; any non-NOP during REF busy. State and memory unchanged.
//  Timer counters saturate at 0; PRE during OPENING is legal and moves the bank to CLOSING.
// TESTING
//  1 reset, ACT b0 row3, wait 2, WRITE col5 0xA5, READ col5 -> DQ_OE=1, DQ_OUT=0xA5 2 cycles after READ.
//  2 ACT b1 then READ b1 next cycle (T_RCD=2) -> CMD_ERR pulse, DQ_OE stays 0, BANK_OPEN[1]=0 then 1.
//  3 4 WRITEs cols 0..3 (0x10..0x13), 4 back-to-back READs -> 0x10,0x11,0x12,0x13 on 4 consecutive cycles.
//  4 both banks open, PRE with A[11]=1 -> BANK_OPEN=00; ACT after 1 cycle -> CMD_ERR; after 2 -> accepted.
//  5 REF with b0 open -> CMD_ERR; after PRE+T_RP, REF then ACT at +2 -> CMD_ERR, ACT at +4 -> accepted.
//  6 READ issued, RST_N=0 next cycle -> DQ_OE never asserts, DQ_OUT=0, BANK_OPEN=0.

Source files
------------

// File: rtl/sdram_multibank_model.sv
// SDRAM behavioural target: command decode, per-bank open-row state with
// tRCD/tRP/tRFC timing, backing array and CAS-latency read pipeline.
module sdram_multibank_model #(
  parameter int DW      = 8,
  parameter int AW      = 12,
  parameter int ROW_W   = 4,
  parameter int COL_W   = 4,
  parameter int BA_W    = 1,
  parameter int CAS_LAT = 2,
  parameter int T_RCD   = 2,
  parameter int T_RP    = 2,
  parameter int T_RFC   = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CS,
  input  logic                 RAS,
  input  logic                 CAS,
  input  logic                 WE,
  input  logic [BA_W-1:0]      BA,
  input  logic [AW-1:0]        A,
  input  logic [DW-1:0]        DQ_IN,
  output logic [DW-1:0]        DQ_OUT,
  output logic                 DQ_OE,
  output logic [(2**BA_W)-1:0] BANK_OPEN,
  output logic                 CMD_ERR
);

  localparam int BANKS = 2 ** BA_W;
  localparam int IDX_W = BA_W + ROW_W + COL_W;
  localparam int TW    = 8;

  typedef enum logic [1:0] {B_IDLE, B_OPENING, B_ACTIVE, B_CLOSING} bank_state_t;
  typedef enum logic [2:0] {C_NOP, C_ACT, C_READ, C_WRITE, C_PRE, C_REF, C_ILL} cmd_t;

  bank_state_t      st      [BANKS];
  bank_state_t      st_nxt  [BANKS];
  logic [TW-1:0]    tmr     [BANKS];
  logic [TW-1:0]    tmr_nxt [BANKS];
  logic [ROW_W-1:0] row     [BANKS];
  logic [ROW_W-1:0] row_nxt [BANKS];
  logic [TW-1:0]    rfc;
  logic [TW-1:0]    rfc_nxt;
  cmd_t             cmd;
  logic             err;
  logic             do_rd;
  logic             do_wr;
  logic [DW-1:0]    mem [2**IDX_W];
  logic [IDX_W-1:0] idx;
  logic [DW-1:0]    pd [CAS_LAT];
  logic [CAS_LAT-1:0] pv;
  logic             unused_a;

  assign unused_a = ^A;
  assign idx      = {BA, row[BA], A[COL_W-1:0]};

  // Decode the strobe pins into a command
  always_comb begin
    cmd = C_NOP;
    if (CS) begin
      unique case ({RAS, CAS, WE})
        3'b000:  cmd = C_NOP;
        3'b100:  cmd = C_ACT;
        3'b010:  cmd = C_READ;
        3'b011:  cmd = C_WRITE;
        3'b101:  cmd = C_PRE;
        3'b110:  cmd = C_REF;
        default: cmd = C_ILL;
      endcase
    end
  end

  // Bank/refresh next state: timers count down first, then a legal command overrides
  always_comb begin
    err     = 1'b0;
    do_rd   = 1'b0;
    do_wr   = 1'b0;
    rfc_nxt = (rfc != '0) ? rfc - 1'b1 : '0;
    for (int unsigned b = 0; b < BANKS; b++) begin
      st_nxt[b]  = st[b];
      tmr_nxt[b] = tmr[b];
      row_nxt[b] = row[b];
      if (st[b] == B_OPENING || st[b] == B_CLOSING) begin
        if (tmr[b] <= TW'(1)) begin
          st_nxt[b]  = (st[b] == B_OPENING) ? B_ACTIVE : B_IDLE;
          tmr_nxt[b] = '0;
        end else begin
          tmr_nxt[b] = tmr[b] - 1'b1;
        end
      end
    end
    if (rfc != '0 && cmd != C_NOP) begin
      err = 1'b1;
    end else begin
      unique case (cmd)
        C_NOP: ;
        C_ACT: begin
          if (st[BA] != B_IDLE) begin
            err = 1'b1;
          end else begin
            row_nxt[BA] = A[ROW_W-1:0];
            if (T_RCD <= 1) begin
              st_nxt[BA]  = B_ACTIVE;
              tmr_nxt[BA] = '0;
            end else begin
              st_nxt[BA]  = B_OPENING;
              tmr_nxt[BA] = TW'(T_RCD - 1);
            end
          end
        end
        C_READ, C_WRITE: begin
          if (st[BA] != B_ACTIVE) err = 1'b1;
          else if (cmd == C_READ) do_rd = 1'b1;
          else do_wr = 1'b1;
        end
        C_PRE: begin
          for (int unsigned b = 0; b < BANKS; b++) begin
            if ((A[AW-1] || BA_W'(b) == BA) && st[b] != B_IDLE) begin
              if (T_RP <= 1) begin
                st_nxt[b]  = B_IDLE;
                tmr_nxt[b] = '0;
              end else begin
                st_nxt[b]  = B_CLOSING;
                tmr_nxt[b] = TW'(T_RP - 1);
              end
            end
          end
        end
        C_REF: begin
          for (int unsigned b = 0; b < BANKS; b++) begin
            if (st[b] != B_IDLE) err = 1'b1;
          end
          if (!err) rfc_nxt = TW'(T_RFC - 1);
        end
        default: err = 1'b1;
      endcase
    end
  end

  // State register for banks, refresh timer and error pulse
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int unsigned b = 0; b < BANKS; b++) begin
        st[b]  <= B_IDLE;
        tmr[b] <= '0;
        row[b] <= '0;
      end
      rfc     <= '0;
      CMD_ERR <= 1'b0;
    end else begin
      for (int unsigned b = 0; b < BANKS; b++) begin
        st[b]  <= st_nxt[b];
        tmr[b] <= tmr_nxt[b];
        row[b] <= row_nxt[b];
      end
      rfc     <= rfc_nxt;
      CMD_ERR <= err;
    end
  end

  // Backing array; not cleared by reset
  always_ff @(posedge CLK) begin
    if (RST_N && do_wr) mem[idx] <= DQ_IN;
  end

  // Read pipeline: data captured at the command edge emerges CAS_LAT edges later
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pv <= '0;
      for (int unsigned i = 0; i < CAS_LAT; i++) pd[i] <= '0;
      DQ_OE  <= 1'b0;
      DQ_OUT <= '0;
    end else begin
      pv[0] <= do_rd;
      pd[0] <= mem[idx];
      for (int unsigned i = 1; i < CAS_LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      DQ_OE <= pv[CAS_LAT-1];
      if (pv[CAS_LAT-1]) DQ_OUT <= pd[CAS_LAT-1];
    end
  end

  // Bank is reported open only once tRCD has elapsed
  always_comb begin
    BANK_OPEN = '0;
    for (int unsigned b = 0; b < BANKS; b++) BANK_OPEN[b] = (st[b] == B_ACTIVE);
  end

endmodule

// File: tb/tb_sdram_multibank_model.sv
// Bench for sdram_multibank_model: directed scenarios plus randomized traffic
// against a cycle-stamped reference model.
module tb_sdram_multibank_model;
  localparam int DW = 8, AW = 12, ROW_W = 4, COL_W = 4, BA_W = 1;
  localparam int CAS_LAT = 2, T_RCD = 2, T_RP = 2, T_RFC = 4;
  localparam int BANKS = 2 ** BA_W;
  localparam logic [2:0] NOP = 3'b000, ACT = 3'b100, RD = 3'b010, WR = 3'b011,
                         PRE = 3'b101, REF = 3'b110;

  logic CLK = 1'b0;
  logic RST_N = 1'b0, CS = 1'b0, RAS = 1'b0, CAS = 1'b0, WE = 1'b0;
  logic [BA_W-1:0] BA = '0;
  logic [AW-1:0] A = '0;
  logic [DW-1:0] DQ_IN = '0;
  logic [DW-1:0] DQ_OUT;
  logic DQ_OE, CMD_ERR;
  logic [BANKS-1:0] BANK_OPEN;

  always #5 CLK = ~CLK;

  sdram_multibank_model #(.DW(DW), .AW(AW), .ROW_W(ROW_W), .COL_W(COL_W), .BA_W(BA_W),
    .CAS_LAT(CAS_LAT), .T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC)) dut (
    .CLK(CLK), .RST_N(RST_N), .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE), .BA(BA), .A(A),
    .DQ_IN(DQ_IN), .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE), .BANK_OPEN(BANK_OPEN), .CMD_ERR(CMD_ERR));

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: each bank remembers when it was activated / precharged
  int cyc = 0;
  bit opened [BANKS];
  int act_at [BANKS];
  int pre_at [BANKS];
  int row_m  [BANKS];
  int ref_at = -1000;
  logic [DW-1:0] mem_m [int];
  logic [DW:0]   rd_due [int];
  logic exp_oe = 1'b0, exp_err = 1'b0;
  logic [DW-1:0] exp_dq = '0;
  bit exp_dq_known = 1'b1;
  logic [BANKS-1:0] exp_open = '0;

  function automatic bit nonidle(int b, int c);
    return opened[b] || (c < pre_at[b] + T_RP);
  endfunction

  task automatic step(input bit rst_n, input bit cs, input logic [2:0] code,
                      input int ba, input int a, input int dq);
    bit err;
    int idx;
    RST_N = rst_n; CS = cs; {RAS, CAS, WE} = code;
    BA = BA_W'(ba); A = AW'(a); DQ_IN = DW'(dq);
    @(posedge CLK);
    err = 1'b0;
    if (!rst_n) begin
      for (int b = 0; b < BANKS; b++) begin
        opened[b] = 1'b0; act_at[b] = -1000; pre_at[b] = -1000;
      end
      ref_at = -1000;
      rd_due.delete();
    end else if (cs) begin
      if (cyc < ref_at + T_RFC && code != NOP) err = 1'b1;
      else begin
        case (code)
          NOP: ;
          ACT: if (nonidle(ba, cyc)) err = 1'b1;
               else begin opened[ba] = 1'b1; act_at[ba] = cyc; row_m[ba] = a % (1 << ROW_W); end
          RD, WR: begin
            if (!opened[ba] || cyc < act_at[ba] + T_RCD) err = 1'b1;
            else begin
              idx = (ba * (1 << ROW_W) + row_m[ba]) * (1 << COL_W) + a % (1 << COL_W);
              if (code == WR) mem_m[idx] = DW'(dq);
              else rd_due[cyc + CAS_LAT] = mem_m.exists(idx) ? {1'b1, mem_m[idx]} : '0;
            end
          end
          PRE: for (int b = 0; b < BANKS; b++)
                 if ((((a >> (AW-1)) & 1) != 0 || b == ba) && nonidle(b, cyc)) begin
                   opened[b] = 1'b0; pre_at[b] = cyc;
                 end
          REF: begin
            for (int b = 0; b < BANKS; b++) if (nonidle(b, cyc)) err = 1'b1;
            if (!err) ref_at = cyc;
          end
          default: err = 1'b1;
        endcase
      end
    end
    exp_err = err;
    for (int b = 0; b < BANKS; b++) exp_open[b] = opened[b] && (cyc + 1 >= act_at[b] + T_RCD);
    if (!rst_n) begin
      exp_oe = 1'b0; exp_dq = '0; exp_dq_known = 1'b1;
    end else if (rd_due.exists(cyc)) begin
      exp_oe = 1'b1; exp_dq_known = rd_due[cyc][DW]; exp_dq = rd_due[cyc][DW-1:0];
      rd_due.delete(cyc);
    end else begin
      exp_oe = 1'b0;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, NOP, 0, 0, 0);
    step(0, 1, ACT, 0, 0, 0);
    n_checks++; if (DQ_OE !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", DQ_OE); end
    n_checks++; if (DQ_OUT !== '0) begin n_fail++; $display("FAIL reset_dq: got %h want 00", DQ_OUT); end
    n_checks++; if (BANK_OPEN !== '0) begin n_fail++; $display("FAIL reset_open: got %b want 00", BANK_OPEN); end
    n_checks++; if (CMD_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", CMD_ERR); end
  endtask

  task automatic test_write_read();
    step(1, 1, ACT, 0, 3, 0);
    step(1, 0, NOP, 0, 0, 0);
    step(1, 1, WR, 0, 5, 8'hA5);
    n_checks++; if (CMD_ERR !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", CMD_ERR); end
    step(1, 1, RD, 0, 5, 0);
    n_checks++; if (DQ_OE !== 1'b0) begin n_fail++; $display("FAIL rd_oe_early0: got %b want 0", DQ_OE); end
    step(1, 0, NOP, 0, 0, 0);
    n_checks++; if (DQ_OE !== 1'b0) begin n_fail++; $display("FAIL rd_oe_early1: got %b want 0", DQ_OE); end
    step(1, 0, NOP, 0, 0, 0);
    n_checks++; if (DQ_OE !== 1'b1 || DQ_OUT !== 8'hA5)
      begin n_fail++; $display("FAIL rd_data: got oe=%b dq=%h want oe=1 dq=a5", DQ_OE, DQ_OUT); end
    step(1, 0, NOP, 0, 0, 0);
    n_checks++; if (DQ_OE !== 1'b0 || DQ_OUT !== 8'hA5)
      begin n_fail++; $display("FAIL rd_hold: got oe=%b dq=%h want oe=0 dq=a5", DQ_OE, DQ_OUT); end
  endtask

  task automatic test_trcd();
    step(1, 1, ACT, 1, 7, 0);
    n_checks++; if (BANK_OPEN[1] !== 1'b0) begin n_fail++; $display("FAIL trcd_open0: got %b want 0", BANK_OPEN[1]); end
    step(1, 1, RD, 1, 2, 0);
    n_checks++; if (CMD_ERR !== 1'b1) begin n_fail++; $display("FAIL trcd_err: got %b want 1", CMD_ERR); end
    n_checks++; if (BANK_OPEN[1] !== 1'b1) begin n_fail++; $display("FAIL trcd_open1: got %b want 1", BANK_OPEN[1]); end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, NOP, 0, 0, 0);
      n_checks++; if (DQ_OE !== 1'b0) begin n_fail++; $display("FAIL trcd_no_oe: got %b want 0", DQ_OE); end
    end
    n_checks++; if (CMD_ERR !== 1'b0) begin n_fail++; $display("FAIL trcd_pulse: got %b want 0", CMD_ERR); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] dq_seen [6];
    logic oe_seen [6];
    for (int i = 0; i < 4; i++) step(1, 1, WR, 0, i, 8'h10 + i);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) step(1, 1, RD, 0, i, 0);
      else step(1, 0, NOP, 0, 0, 0);
      dq_seen[i] = DQ_OUT; oe_seen[i] = DQ_OE;
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (i < 2) begin
        if (oe_seen[i] !== 1'b0) begin n_fail++; $display("FAIL b2b_oe%0d: got %b want 0", i, oe_seen[i]); end
      end else if (oe_seen[i] !== 1'b1 || dq_seen[i] !== DW'(8'h10 + i - 2)) begin
        n_fail++; $display("FAIL b2b_data%0d: got oe=%b dq=%h want oe=1 dq=%h", i, oe_seen[i], dq_seen[i], 8'h10 + i - 2);
      end
    end
  endtask

  task automatic test_precharge_all();
    n_checks++; if (BANK_OPEN !== 2'b11) begin n_fail++; $display("FAIL pall_before: got %b want 11", BANK_OPEN); end
    step(1, 1, PRE, 0, 1 << (AW-1), 0);
    n_checks++; if (BANK_OPEN !== 2'b00) begin n_fail++; $display("FAIL pall_closed: got %b want 00", BANK_OPEN); end
    step(1, 1, ACT, 0, 3, 0);
    n_checks++; if (CMD_ERR !== 1'b1) begin n_fail++; $display("FAIL pall_act_early: got %b want 1", CMD_ERR); end
    step(1, 1, ACT, 0, 3, 0);
    n_checks++; if (CMD_ERR !== 1'b0) begin n_fail++; $display("FAIL pall_act_ok: got %b want 0", CMD_ERR); end
    step(1, 0, NOP, 0, 0, 0);
    n_checks++; if (BANK_OPEN !== 2'b01) begin n_fail++; $display("FAIL pall_reopen: got %b want 01", BANK_OPEN); end
  endtask

  task automatic test_refresh();
    step(1, 1, REF, 0, 0, 0);
    n_checks++; if (CMD_ERR !== 1'b1) begin n_fail++; $display("FAIL ref_open_err: got %b want 1", CMD_ERR); end
    step(1, 1, PRE, 0, 0, 0);
    step(1, 0, NOP, 0, 0, 0);
    step(1, 1, REF, 0, 0, 0);
    n_checks++; if (CMD_ERR !== 1'b0) begin n_fail++; $display("FAIL ref_ok: got %b want 0", CMD_ERR); end
    step(1, 0, NOP, 0, 0, 0);
    step(1, 1, ACT, 0, 3, 0);
    n_checks++; if (CMD_ERR !== 1'b1) begin n_fail++; $display("FAIL ref_busy_act: got %b want 1", CMD_ERR); end
    step(1, 0, NOP, 0, 0, 0);
    step(1, 1, ACT, 0, 3, 0);
    n_checks++; if (CMD_ERR !== 1'b0) begin n_fail++; $display("FAIL ref_done_act: got %b want 0", CMD_ERR); end
    step(1, 0, NOP, 0, 0, 0);
    n_checks++; if (BANK_OPEN !== 2'b01) begin n_fail++; $display("FAIL ref_reopen: got %b want 01", BANK_OPEN); end
  endtask

  task automatic test_reset_mid_read();
    step(1, 1, RD, 0, 1, 0);
    n_checks++; if (CMD_ERR !== 1'b0) begin n_fail++; $display("FAIL rst_rd_err: got %b want 0", CMD_ERR); end
    step(0, 0, NOP, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, NOP, 0, 0, 0);
      n_checks++;
      if (DQ_OE !== 1'b0 || DQ_OUT !== '0 || BANK_OPEN !== '0) begin
        n_fail++; $display("FAIL rst_mid_read%0d: got oe=%b dq=%h open=%b want 0 00 00", i, DQ_OE, DQ_OUT, BANK_OPEN);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] code;
    int k, a;
    step(0, 0, NOP, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      k = $urandom_range(0, 15);
      case (k)
        0, 1, 2:       code = ACT;
        3, 4, 5, 6:    code = RD;
        7, 8, 9:       code = WR;
        10, 11:        code = PRE;
        12:            code = REF;
        13:            code = ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b111;
        default:       code = NOP;
      endcase
      a = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = a | (1 << (AW-1));
      step($urandom_range(0, 149) != 0, $urandom_range(0, 9) != 0, code,
           $urandom_range(0, BANKS-1), a, $urandom_range(0, 255));
      n_checks++; if (CMD_ERR !== exp_err) begin n_fail++; $display("FAIL rnd_err@%0d: got %b want %b", cyc, CMD_ERR, exp_err); end
      n_checks++; if (BANK_OPEN !== exp_open) begin n_fail++; $display("FAIL rnd_open@%0d: got %b want %b", cyc, BANK_OPEN, exp_open); end
      n_checks++; if (DQ_OE !== exp_oe) begin n_fail++; $display("FAIL rnd_oe@%0d: got %b want %b", cyc, DQ_OE, exp_oe); end
      if (exp_dq_known) begin
        n_checks++; if (DQ_OUT !== exp_dq) begin n_fail++; $display("FAIL rnd_dq@%0d: got %h want %h", cyc, DQ_OUT, exp_dq); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_trcd();
    test_back_to_back();
    test_precharge_all();
    test_refresh();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
